// File: rtl/cci_host_mem_responder_pkg.sv
// Shared types for the CCI host-memory loopback responder.
// The typedef widths are fixed; the top level must be built with matching default parameters.
package cci_host_mem_responder_pkg;

   localparam int CCI_ADDR_BITS      = 42;
   localparam int CCI_MEM_LINES_LOG2 = 6;
   localparam int CCI_MDATA_BITS     = 16;
   localparam int CCI_LINE_BITS      = 512;

   typedef logic [CCI_LINE_BITS-1:0]      t_line;
   typedef logic [CCI_MDATA_BITS-1:0]     t_mdata;
   typedef logic [CCI_MEM_LINES_LOG2-1:0] t_line_idx;

   typedef struct packed {
      logic [CCI_ADDR_BITS-1:0] addr;
      t_mdata                   mdata;
   } t_rd_entry;

   typedef enum logic {S_IDLE, S_GAP} t_state;

endpackage

// File: rtl/cci_host_mem_responder_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rdata_o while not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module mem_rsp_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   occupancy_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] storage_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full_o      = (count_q == CW'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign occupancy_o = count_q;
   assign rdata_o     = storage_q[rd_ptr_q];
   assign do_pop      = pop_i && !empty_o;
   assign do_push     = push_i && (!full_o || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CW'(1);
         else if (!do_push && do_pop) count_q <= count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) storage_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/cci_host_mem_responder.sv
// Loopback host-memory model answering AFU line reads (c0) and line writes (c1).
// Reads are queued and paced out through a fixed-latency pipe; writes are acked after a fixed delay.
module cci_host_mem_responder
   import cci_host_mem_responder_pkg::*;
#(
   parameter int ADDR_BITS      = CCI_ADDR_BITS,
   parameter int MEM_LINES_LOG2 = CCI_MEM_LINES_LOG2,
   parameter int MDATA_BITS     = CCI_MDATA_BITS,
   parameter int FIFO_DEPTH     = 8,
   parameter int ALMFULL_SLACK  = 2,
   parameter int RD_LATENCY     = 4,
   parameter int RSP_GAP        = 1,
   parameter int WR_LATENCY     = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rd_req_valid,
   input  logic [ADDR_BITS-1:0]      rd_req_addr,
   input  logic [MDATA_BITS-1:0]     rd_req_mdata,
   input  logic                      wr_req_valid,
   input  logic [ADDR_BITS-1:0]      wr_req_addr,
   input  logic [MDATA_BITS-1:0]     wr_req_mdata,
   input  logic [511:0]              wr_req_data,
   input  logic                      bd_wr_en,
   input  logic [MEM_LINES_LOG2-1:0] bd_addr,
   input  logic [511:0]              bd_data,
   output logic                      rd_rsp_valid,
   output logic [511:0]              rd_rsp_data,
   output logic [MDATA_BITS-1:0]     rd_rsp_mdata,
   output logic                      wr_rsp_valid,
   output logic [MDATA_BITS-1:0]     wr_rsp_mdata,
   output logic                      almost_full,
   output logic                      err_overflow,
   output logic                      err_range
);

   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int GW    = (RSP_GAP > 1) ? $clog2(RSP_GAP) : 1;
   localparam int LINES = 2 ** MEM_LINES_LOG2;

   t_line     mem [LINES];
   t_state    state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic      pop, push_ok, fifo_full, fifo_empty;
   logic [CW-1:0] occ, occ_d;
   t_rd_entry push_entry, pop_entry;
   logic      rd_in_range, wr_in_range;
   t_line     rd_line;
   logic      almost_full_q, err_overflow_q, err_range_q;

   assign push_entry = '{addr: rd_req_addr, mdata: rd_req_mdata};

   mem_rsp_sync_fifo #(
      .WIDTH ($bits(t_rd_entry)),
      .DEPTH (FIFO_DEPTH)
   ) u_rd_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (rd_req_valid),
      .pop_i       (pop),
      .wdata_i     (push_entry),
      .rdata_o     (pop_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .occupancy_o (occ)
   );

   assign push_ok = rd_req_valid && (!fifo_full || pop);

   always_comb begin
      occ_d = occ;
      if (push_ok && !pop)      occ_d = occ + CW'(1);
      else if (!push_ok && pop) occ_d = occ - CW'(1);
   end

   // Pacing: pop whenever idle and non-empty, then hold off RSP_GAP-1 cycles.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (RSP_GAP > 1) begin
                  state_d = S_GAP;
                  gap_d   = GW'(RSP_GAP - 1);
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - GW'(1);
            if (gap_q == GW'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rd_in_range = ((pop_entry.addr >> MEM_LINES_LOG2) == '0);
   assign wr_in_range = ((wr_req_addr >> MEM_LINES_LOG2) == '0);
   assign rd_line     = rd_in_range ? mem[pop_entry.addr[MEM_LINES_LOG2-1:0]] : '0;

   // The functional write is issued last so it wins a same-line backdoor collision.
   always_ff @(posedge clk) begin
      if (bd_wr_en)                    mem[bd_addr] <= bd_data;
      if (wr_req_valid && wr_in_range) mem[wr_req_addr[MEM_LINES_LOG2-1:0]] <= wr_req_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         gap_q          <= '0;
         almost_full_q  <= 1'b0;
         err_overflow_q <= 1'b0;
         err_range_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         gap_q         <= gap_d;
         almost_full_q <= ((FIFO_DEPTH - int'(occ_d)) <= ALMFULL_SLACK);
         if (rd_req_valid && !push_ok) err_overflow_q <= 1'b1;
         if ((pop && !rd_in_range) || (wr_req_valid && !wr_in_range)) err_range_q <= 1'b1;
      end
   end

   logic [RD_LATENCY-1:0] rd_v_q;
   t_line                 rd_d_q [RD_LATENCY];
   t_mdata                rd_m_q [RD_LATENCY];
   logic [WR_LATENCY-1:0] wr_v_q;
   t_mdata                wr_m_q [WR_LATENCY];

   // Data fields are zeroed on idle slots so the outputs stay quiet between responses.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_v_q <= '0;
         wr_v_q <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            rd_d_q[i] <= '0;
            rd_m_q[i] <= '0;
         end
         for (int i = 0; i < WR_LATENCY; i++) wr_m_q[i] <= '0;
      end else begin
         rd_v_q[0] <= pop;
         rd_d_q[0] <= pop ? rd_line : '0;
         rd_m_q[0] <= pop ? pop_entry.mdata : '0;
         for (int i = 1; i < RD_LATENCY; i++) begin
            rd_v_q[i] <= rd_v_q[i-1];
            rd_d_q[i] <= rd_d_q[i-1];
            rd_m_q[i] <= rd_m_q[i-1];
         end
         wr_v_q[0] <= wr_req_valid;
         wr_m_q[0] <= wr_req_valid ? wr_req_mdata : '0;
         for (int i = 1; i < WR_LATENCY; i++) begin
            wr_v_q[i] <= wr_v_q[i-1];
            wr_m_q[i] <= wr_m_q[i-1];
         end
      end
   end

   assign rd_rsp_valid = rd_v_q[RD_LATENCY-1];
   assign rd_rsp_data  = rd_d_q[RD_LATENCY-1];
   assign rd_rsp_mdata = rd_m_q[RD_LATENCY-1];
   assign wr_rsp_valid = wr_v_q[WR_LATENCY-1];
   assign wr_rsp_mdata = wr_m_q[WR_LATENCY-1];
   assign almost_full  = almost_full_q;
   assign err_overflow = err_overflow_q;
   assign err_range    = err_range_q;

endmodule

// File: tb/tb_cci_host_mem_responder.sv
// Self-checking bench for cci_host_mem_responder (RSP_GAP=3).
// Expected responses are queued when requests are driven and matched as the DUT emits them.
module tb_cci_host_mem_responder;
   import cci_host_mem_responder_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req_valid, wr_req_valid, bd_wr_en;
   logic [41:0] rd_req_addr, wr_req_addr;
   t_mdata      rd_req_mdata, wr_req_mdata;
   t_line       wr_req_data, bd_data;
   t_line_idx   bd_addr;
   logic        rd_rsp_valid, wr_rsp_valid, almost_full, err_overflow, err_range;
   t_line       rd_rsp_data;
   t_mdata      rd_rsp_mdata, wr_rsp_mdata;

   cci_host_mem_responder #(.RSP_GAP(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .rd_req_valid (rd_req_valid),
      .rd_req_addr  (rd_req_addr),
      .rd_req_mdata (rd_req_mdata),
      .wr_req_valid (wr_req_valid),
      .wr_req_addr  (wr_req_addr),
      .wr_req_mdata (wr_req_mdata),
      .wr_req_data  (wr_req_data),
      .bd_wr_en     (bd_wr_en),
      .bd_addr      (bd_addr),
      .bd_data      (bd_data),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_data  (rd_rsp_data),
      .rd_rsp_mdata (rd_rsp_mdata),
      .wr_rsp_valid (wr_rsp_valid),
      .wr_rsp_mdata (wr_rsp_mdata),
      .almost_full  (almost_full),
      .err_overflow (err_overflow),
      .err_range    (err_range)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {K_RD, K_WR, K_BD} t_kind;
   typedef struct {
      t_line  data;
      t_mdata mdata;
      int     exp_cyc;
   } t_exp;
   typedef struct {
      t_kind       kind;
      logic [41:0] addr;
      t_mdata      mdata;
      t_line       wdata;
      t_line       rexp;
      int          gap;
   } t_vec;

   t_exp rd_q[$];
   t_exp wr_q[$];
   t_exp re, we;
   t_vec vecs [8];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   rd_rsp_cnt = 0;

   task automatic checkOutput(input string name, input t_line act, input t_line exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checkOutput(name, t_line'(act), t_line'(exp));
   endtask

   // Response monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rd_rsp_valid) begin
         rd_rsp_cnt++;
         if (rd_q.size() == 0) checkBit("rd_unexpected", 1'b1, 1'b0);
         else begin
            re = rd_q.pop_front();
            checkOutput("rd_data", rd_rsp_data, re.data);
            checkOutput("rd_mdata", t_line'(rd_rsp_mdata), t_line'(re.mdata));
            if (re.exp_cyc >= 0) checkOutput("rd_cycle", t_line'(cyc), t_line'(re.exp_cyc));
         end
      end
      if (wr_rsp_valid) begin
         if (wr_q.size() == 0) checkBit("wr_unexpected", 1'b1, 1'b0);
         else begin
            we = wr_q.pop_front();
            checkOutput("wr_mdata", t_line'(wr_rsp_mdata), t_line'(we.mdata));
            if (we.exp_cyc >= 0) checkOutput("wr_cycle", t_line'(cyc), t_line'(we.exp_cyc));
         end
      end
   end

   task automatic clearInputs();
      rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_mdata = '0;
      wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_mdata = '0; wr_req_data = '0;
      bd_wr_en = 1'b0; bd_addr = '0; bd_data = '0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(negedge clk);
         clearInputs();
      end
   endtask

   task automatic applyStimulus(input t_kind kind, input logic [41:0] addr, input t_mdata md,
                                input t_line data, input t_line rexp);
      @(negedge clk);
      clearInputs();
      case (kind)
         K_RD: begin
            rd_req_valid = 1'b1; rd_req_addr = addr; rd_req_mdata = md;
            rd_q.push_back('{rexp, md, cyc + 5});
         end
         K_WR: begin
            wr_req_valid = 1'b1; wr_req_addr = addr; wr_req_mdata = md; wr_req_data = data;
            wr_q.push_back('{'0, md, cyc + 2});
         end
         default: begin
            bd_wr_en = 1'b1; bd_addr = addr[5:0]; bd_data = data;
         end
      endcase
   endtask

   task automatic waitDrain();
      int t = 0;
      while ((rd_q.size() != 0 || wr_q.size() != 0) && t < 300) begin
         @(negedge clk);
         clearInputs();
         t++;
      end
      checkOutput("drain_timeout", t_line'(rd_q.size() + wr_q.size()), t_line'(0));
      idleCycles(8);
   endtask

   task automatic checkAllZero(input string tag);
      checkBit({tag, "_rd_valid"}, rd_rsp_valid, 1'b0);
      checkOutput({tag, "_rd_data"}, rd_rsp_data, '0);
      checkOutput({tag, "_rd_mdata"}, t_line'(rd_rsp_mdata), '0);
      checkBit({tag, "_wr_valid"}, wr_rsp_valid, 1'b0);
      checkOutput({tag, "_wr_mdata"}, t_line'(wr_rsp_mdata), '0);
      checkBit({tag, "_almfull"}, almost_full, 1'b0);
      checkBit({tag, "_err_ovf"}, err_overflow, 1'b0);
      checkBit({tag, "_err_range"}, err_range, 1'b0);
   endtask

   function automatic t_line burstPat(input int k);
      return {16{32'hB000_0000 + k}};
   endfunction

   initial begin
      int c0, cnt0;
      vecs[0] = '{K_RD, 42'd3,     16'h0011, '0,            512'hA5,        6};
      vecs[1] = '{K_WR, 42'd5,     16'h0007, 512'hDEAD,     '0,             0};
      vecs[2] = '{K_RD, 42'd5,     16'h0008, '0,            512'hDEAD,      6};
      vecs[3] = '{K_WR, 42'd10,    16'h0003, 512'h12345678, '0,             0};
      vecs[4] = '{K_RD, 42'd10,    16'h0004, '0,            512'h12345678,  6};
      vecs[5] = '{K_RD, 42'h40,    16'h0022, '0,            '0,             6};
      vecs[6] = '{K_WR, 42'h45,    16'h0009, 512'hFFFF,     '0,             1};
      vecs[7] = '{K_RD, 42'd5,     16'h000A, '0,            512'hDEAD,      6};

      clearInputs();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      reset = 1'b0;

      applyStimulus(K_BD, 42'd3,  '0, 512'hA5, '0);
      applyStimulus(K_BD, 42'd12, '0, 512'hC0, '0);
      applyStimulus(K_BD, 42'd50, '0, 512'h5050, '0);
      idleCycles(2);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].kind, vecs[i].addr, vecs[i].mdata, vecs[i].wdata, vecs[i].rexp);
         if (vecs[i].gap > 0) idleCycles(vecs[i].gap);
      end
      waitDrain();
      checkBit("err_range_set", err_range, 1'b1);
      checkBit("err_ovf_clear", err_overflow, 1'b0);

      // Backdoor and functional write in the same cycle: same line, then different lines.
      @(negedge clk);
      clearInputs();
      bd_wr_en = 1'b1; bd_addr = 6'd20; bd_data = 512'h1111;
      wr_req_valid = 1'b1; wr_req_addr = 42'd20; wr_req_mdata = 16'h0040; wr_req_data = 512'h2222;
      wr_q.push_back('{'0, 16'h0040, cyc + 2});
      @(negedge clk);
      clearInputs();
      bd_wr_en = 1'b1; bd_addr = 6'd21; bd_data = 512'h3333;
      wr_req_valid = 1'b1; wr_req_addr = 42'd22; wr_req_mdata = 16'h0041; wr_req_data = 512'h4444;
      wr_q.push_back('{'0, 16'h0041, cyc + 2});
      idleCycles(1);
      applyStimulus(K_RD, 42'd20, 16'h0050, '0, 512'h2222); idleCycles(6);
      applyStimulus(K_RD, 42'd21, 16'h0051, '0, 512'h3333); idleCycles(6);
      applyStimulus(K_RD, 42'd22, 16'h0052, '0, 512'h4444); idleCycles(6);

      // Write commits in the read's pop cycle: the read sees the old line.
      applyStimulus(K_RD, 42'd12, 16'h0060, '0, 512'hC0);
      applyStimulus(K_WR, 42'd12, 16'h0033, 512'hBEEF, '0);
      idleCycles(6);
      applyStimulus(K_RD, 42'd12, 16'h0061, '0, 512'hBEEF);
      waitDrain();

      // Burst of 13 reads: pops every 3 cycles, FIFO fills on the 12th, the 13th is dropped.
      for (int k = 0; k < 13; k++) applyStimulus(K_BD, 42'(32 + k), '0, burstPat(k), '0);
      idleCycles(2);
      cnt0 = rd_rsp_cnt;
      c0 = 0;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         clearInputs();
         if (k == 0) c0 = cyc;
         if (k == 8)  checkBit("almfull_occ5", almost_full, 1'b0);
         if (k == 9)  checkBit("almfull_occ6", almost_full, 1'b1);
         if (k == 12) checkBit("ovf_before_drop", err_overflow, 1'b0);
         rd_req_valid = 1'b1; rd_req_addr = 42'(32 + k); rd_req_mdata = t_mdata'(16'h0100 + k);
         if (k < 12) rd_q.push_back('{burstPat(k), t_mdata'(16'h0100 + k), c0 + 5 + 3 * k});
      end
      @(negedge clk);
      clearInputs();
      checkBit("ovf_after_drop", err_overflow, 1'b1);
      checkBit("almfull_full", almost_full, 1'b1);
      waitDrain();
      checkOutput("burst_rsp_count", t_line'(rd_rsp_cnt - cnt0), t_line'(12));

      // Reset with reads queued: nothing emerges afterwards, memory survives.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         clearInputs();
         rd_req_valid = 1'b1; rd_req_addr = 42'd50; rd_req_mdata = t_mdata'(16'h0200 + k);
      end
      @(negedge clk);
      clearInputs();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkAllZero("midreset");
      reset = 1'b0;
      idleCycles(20);
      checkAllZero("postreset");
      applyStimulus(K_RD, 42'd50, 16'h0300, '0, 512'h5050); idleCycles(6);
      applyStimulus(K_RD, 42'd3,  16'h0301, '0, 512'hA5);
      waitDrain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
